camera_capture_ctrl: RTL and testbench

//  Wishbone camera capture slave for ZPUino: samples an 8-bit parallel DVP camera (pclk/vsync/href/data)
//  in the bus clock domain, crops a register-programmable window, packs bytes into 32-bit words and

---
 rtl/camera_capture_pkg.sv | 42 ++++
 rtl/cam_byte_packer.sv | 54 +++++
 rtl/camera_capture_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_camera_capture_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_capture_pkg.sv
// Shared definitions for the DVP camera capture slave: register map, bit
// positions, pixel format encodings and the capture FSM state type.
package camera_capture_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_WIN_H  = 3'd2;
    localparam logic [2:0] REG_WIN_V  = 3'd3;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_FMT    = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 16;

    // Both window registers keep the length field at bit 16.
    localparam int WIN_LEN_LSB = 16;

    localparam logic FMT_RGB565 = 1'b0;
    localparam logic FMT_Y_ONLY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    // True when pos lies in [start, start+len-1]; len==0 is an empty window.
    function automatic logic in_window(input logic [15:0] pos,
                                       input logic [15:0] start,
                                       input logic [15:0] len);
        logic [16:0] rel;
        rel = {1'b0, pos} - {1'b0, start};
        return (pos >= start) && (rel < {1'b0, len});
    endfunction

endpackage

// File: rtl/cam_byte_packer.sv
// Packs kept camera bytes little-endian into 32-bit words; a flush emits a
// zero-padded partial word, clear discards whatever has been gathered.
module cam_byte_packer (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        clear,
    input  logic        flush,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    output logic        word_vld,
    output logic [31:0] word
);

    logic [23:0] acc;
    logic [1:0]  fill;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            acc  <= '0;
            fill <= '0;
        end else if (clear || flush) begin
            acc  <= '0;
            fill <= '0;
        end else if (byte_vld) begin
            if (fill == 2'd3) begin
                acc <= '0;
            end else begin
                case (fill)
                    2'd0:    acc[7:0]   <= byte_data;
                    2'd1:    acc[15:8]  <= byte_data;
                    default: acc[23:16] <= byte_data;
                endcase
            end
            fill <= fill + 2'd1;
        end
    end

    // The word leaves in the same cycle as its last byte so the frame-end
    // flush lands in VRAM before the FSM latches the word count.
    always_comb begin
        word_vld = 1'b0;
        word     = '0;
        if (!clear) begin
            if (flush) begin
                word_vld = (fill != 2'd0);
                word     = {8'h00, acc};
            end else if (byte_vld && fill == 2'd3) begin
                word_vld = 1'b1;
                word     = {byte_data, acc};
            end
        end
    end

endmodule

// File: rtl/camera_capture_ctrl.sv
// Wishbone camera capture slave: synchronises a DVP camera into wb_clk_i,
// crops a programmable window, packs bytes into words and stores them in VRAM.
module camera_capture_ctrl
    import camera_capture_pkg::*;
#(
    parameter int VRAM_AW     = 13,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:2] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        wb_inta_o,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output cap_state_e  dbg_state
);

    localparam int DEPTH = 1 << VRAM_AW;

    // ---------------- camera input synchronisers ----------------
    logic [SYNC_STAGES-1:0]      pclk_sync, vsync_sync, href_sync;
    logic [SYNC_STAGES-1:0][7:0] data_sync;
    logic                        pclk_d, href_d, vsync_d;
    logic                        pclk_s, href_s, vsync_s;
    logic [7:0]                  data_s;
    logic                        byte_strobe, href_fall, vsync_rise;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            data_sync  <= '0;
            pclk_d     <= 1'b0;
            href_d     <= 1'b0;
            vsync_d    <= 1'b0;
        end else begin
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
            href_sync  <= {href_sync[SYNC_STAGES-2:0], cam_href};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], cam_data};
            pclk_d     <= pclk_s;
            href_d     <= href_s;
            vsync_d    <= vsync_s;
        end
    end

    // All camera signals are taken from the same stage to stay aligned.
    assign pclk_s      = pclk_sync[SYNC_STAGES-1];
    assign href_s      = href_sync[SYNC_STAGES-1];
    assign vsync_s     = vsync_sync[SYNC_STAGES-1];
    assign data_s      = data_sync[SYNC_STAGES-1];
    assign byte_strobe = pclk_s & ~pclk_d;
    assign href_fall   = href_d & ~href_s;
    assign vsync_rise  = vsync_s & ~vsync_d;

    // ---------------- line / byte position ----------------
    logic [CNT_W-1:0] line_cnt, byte_cnt;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            line_cnt <= '0;
            byte_cnt <= '0;
        end else if (vsync_rise) begin
            line_cnt <= '0;
            byte_cnt <= '0;
        end else if (href_fall) begin
            line_cnt <= line_cnt + 1'b1;
            byte_cnt <= '0;
        end else if (byte_strobe && href_s) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // ---------------- Wishbone decode ----------------
    // Handshake: a request is accepted when cyc&stb are high and ack is low;
    // ack is then high for exactly one cycle carrying the read data, so
    // back-to-back transfers always see one idle cycle in between.
    logic       wb_req, sel_vram, reg_wr;
    logic       ctrl_wr, stat_wr, winh_wr, winv_wr;
    logic [2:0] reg_idx;
    logic       unused_bits;

    assign wb_req   = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign sel_vram = wb_adr_i[15];
    assign reg_idx  = wb_adr_i[4:2];
    assign reg_wr   = wb_req & wb_we_i & ~sel_vram;
    assign ctrl_wr  = reg_wr && (reg_idx == REG_CTRL);
    assign stat_wr  = reg_wr && (reg_idx == REG_STATUS);
    assign winh_wr  = reg_wr && (reg_idx == REG_WIN_H);
    assign winv_wr  = reg_wr && (reg_idx == REG_WIN_V);
    assign unused_bits = ^{wb_adr_i, wb_dat_i};

    // ---------------- registers ----------------
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] h_start, h_len, v_start, v_len;
    logic             frame_done, overflow;
    logic [15:0]      last_cnt;
    logic [VRAM_AW:0] wr_cnt;

    cap_state_e state, state_nxt;
    logic       busy, capturing, done_pulse, cap_entry, pk_clear, pk_flush;

    // ---------------- capture FSM ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ctrl[CTRL_START]) state_nxt = ST_ARM;
            // A CTRL write in the same cycle takes precedence over the vsync.
            ST_ARM:     if (vsync_rise && !ctrl_wr) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (vsync_rise) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ctrl[CTRL_CONT] ? ST_CAPTURE : ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (!ctrl[CTRL_START] && state != ST_IDLE) state_nxt = ST_IDLE;
    end

    always_comb begin
        busy       = (state == ST_ARM) || (state == ST_CAPTURE);
        capturing  = (state == ST_CAPTURE) && ctrl[CTRL_START];
        done_pulse = (state == ST_DONE);
        cap_entry  = (state_nxt == ST_CAPTURE) && (state != ST_CAPTURE);
        pk_clear   = (state != ST_CAPTURE);
        pk_flush   = capturing && vsync_rise;
    end

    assign dbg_state = state;

    // ---------------- byte selection and packing ----------------
    logic        in_win, fmt_keep, pk_byte_vld, pk_word_vld;
    logic [31:0] pk_word;
    logic        vram_full, vram_we;

    always_comb begin
        in_win = in_window(16'(line_cnt), 16'(v_start), 16'(v_len)) &&
                 in_window(16'(byte_cnt), 16'(h_start), 16'(h_len));
        fmt_keep    = (ctrl[CTRL_FMT] == FMT_RGB565) || !byte_cnt[0];
        pk_byte_vld = capturing && byte_strobe && href_s && in_win && fmt_keep;
    end

    cam_byte_packer u_packer (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clear     (pk_clear),
        .flush     (pk_flush),
        .byte_vld  (pk_byte_vld),
        .byte_data (data_s),
        .word_vld  (pk_word_vld),
        .word      (pk_word)
    );

    // wr_cnt reaching DEPTH means the VRAM is full; extra words are dropped.
    assign vram_full = wr_cnt[VRAM_AW];
    assign vram_we   = pk_word_vld && !vram_full;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)     wr_cnt <= '0;
        else if (cap_entry) wr_cnt <= '0;
        else if (vram_we) wr_cnt <= wr_cnt + 1'b1;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ctrl       <= '0;
            h_start    <= '0;
            h_len      <= '0;
            v_start    <= '0;
            v_len      <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            last_cnt   <= '0;
        end else begin
            if (ctrl_wr)
                ctrl <= wb_dat_i[3:0];
            else if (done_pulse && !ctrl[CTRL_CONT])
                ctrl[CTRL_START] <= 1'b0;
            if (winh_wr) begin
                h_start <= wb_dat_i[CNT_W-1:0];
                h_len   <= wb_dat_i[WIN_LEN_LSB +: CNT_W];
            end
            if (winv_wr) begin
                v_start <= wb_dat_i[CNT_W-1:0];
                v_len   <= wb_dat_i[WIN_LEN_LSB +: CNT_W];
            end
            // Setting wins over a coincident write-one-to-clear.
            if (done_pulse)                           frame_done <= 1'b1;
            else if (stat_wr && wb_dat_i[STAT_DONE])  frame_done <= 1'b0;
            if (pk_word_vld && vram_full)             overflow <= 1'b1;
            else if (stat_wr && wb_dat_i[STAT_OVF])   overflow <= 1'b0;
            if (done_pulse) last_cnt <= 16'(wr_cnt);
        end
    end

    assign wb_inta_o = frame_done & ctrl[CTRL_IRQ_EN];

    // ---------------- VRAM (simple dual-port, read-old on collision) ----------------
    logic [31:0]        vram [DEPTH];
    logic [31:0]        vram_q;
    logic [VRAM_AW-1:0] rd_addr;

    assign rd_addr = wb_adr_i[VRAM_AW+1:2];

    always_ff @(posedge wb_clk_i) begin
        if (vram_we)             vram[wr_cnt[VRAM_AW-1:0]] <= pk_word;
        if (wb_req && sel_vram)  vram_q <= vram[rd_addr];
    end

    // ---------------- read data / ack ----------------
    logic [31:0] reg_rdata, reg_q;
    logic        sel_vram_q;

    always_comb begin
        reg_rdata = '0;
        case (reg_idx)
            REG_CTRL:   reg_rdata[3:0] = ctrl;
            REG_STATUS: begin
                reg_rdata[STAT_BUSY]          = busy;
                reg_rdata[STAT_DONE]          = frame_done;
                reg_rdata[STAT_OVF]           = overflow;
                reg_rdata[STAT_CNT_LSB +: 16] = last_cnt;
            end
            REG_WIN_H: begin
                reg_rdata[CNT_W-1:0]           = h_start;
                reg_rdata[WIN_LEN_LSB +: CNT_W] = h_len;
            end
            REG_WIN_V: begin
                reg_rdata[CNT_W-1:0]           = v_start;
                reg_rdata[WIN_LEN_LSB +: CNT_W] = v_len;
            end
            default: reg_rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o   <= 1'b0;
            reg_q      <= '0;
            sel_vram_q <= 1'b0;
        end else begin
            wb_ack_o <= wb_req;
            if (wb_req) begin
                reg_q      <= reg_rdata;
                sel_vram_q <= sel_vram;
            end
        end
    end

    assign wb_dat_o = !wb_ack_o ? 32'h0 : (sel_vram_q ? vram_q : reg_q);

endmodule

// File: tb/tb_camera_capture_ctrl.sv
// Directed bench for camera_capture_ctrl with a 16-word VRAM: capture,
// cropping, formats, overflow, continuous mode and collision corner cases.
module tb_camera_capture_ctrl;
    import camera_capture_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:2] wb_adr;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_inta;
    logic        cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_data;
    cap_state_e  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] rd;

    camera_capture_ctrl #(.VRAM_AW(4), .SYNC_STAGES(2), .CNT_W(12)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we_i   (wb_we),
        .wb_stb_i  (wb_stb),
        .wb_cyc_i  (wb_cyc),
        .wb_ack_o  (wb_ack),
        .wb_inta_o (wb_inta),
        .cam_pclk  (cam_pclk),
        .cam_vsync (cam_vsync),
        .cam_href  (cam_href),
        .cam_data  (cam_data),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:2] ra(input logic [2:0] r);
        return {11'h000, r};
    endfunction

    function automatic logic [15:2] va(input int w);
        return 14'h2000 | 14'(w);
    endfunction

    // ---------------- Wishbone driver (call on a negedge) ----------------
    task automatic wb_write(input logic [15:2] adr, input logic [31:0] dat);
        wb_adr = adr; wb_dat_i = dat; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        chk("wr_ack", 32'(wb_ack), 32'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("wr_ack_low", 32'(wb_ack), 32'd0);
    endtask

    task automatic wb_read(input logic [15:2] adr, output logic [31:0] dat);
        wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        chk("rd_ack", 32'(wb_ack), 32'd1);
        dat = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [15:2] adr, input logic [31:0] exp);
        logic [31:0] v;
        wb_read(adr, v);
        chk(tag, v, exp);
    endtask

    // ---------------- camera driver ----------------
    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (6) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic line_begin();
        cam_href = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        cam_data = v; cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_href = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_line(input logic [7:0] base, input int n);
        line_begin();
        for (int i = 0; i < n; i++) send_byte(base + 8'(i));
        line_end();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        wb_adr = '0; wb_dat_i = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(wb_ack), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_inta", 32'(wb_inta), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        rd_chk("rst_status", ra(REG_STATUS), 32'h0);
        rd_chk("rst_ctrl", ra(REG_CTRL), 32'h0);

        // 1: reset in the middle of a capture
        wb_write(ra(REG_WIN_H), 32'h0010_0000);
        wb_write(ra(REG_WIN_V), 32'h0004_0000);
        wb_write(ra(REG_CTRL), 32'h1);
        vsync_pulse();
        chk("t1_capture", 32'(dbg_state), 32'(ST_CAPTURE));
        line_begin();
        for (int i = 0; i < 3; i++) send_byte(8'(i));
        cam_pclk = 1'b0; cam_href = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("t1_ack", 32'(wb_ack), 32'd0);
        chk("t1_idle", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);
        rd_chk("t1_status", ra(REG_STATUS), 32'h0);
        rd_chk("t1_winh", ra(REG_WIN_H), 32'h0);
        wb_write(ra(REG_CTRL), 32'h1);
        repeat (10) @(negedge clk);
        chk("t1_arm_wait", 32'(dbg_state), 32'(ST_ARM));
        vsync_pulse();
        chk("t1_arm_go", 32'(dbg_state), 32'(ST_CAPTURE));
        wb_write(ra(REG_CTRL), 32'h0);

        // 2: RGB565 window (4,16) x (2,3), single shot with irq
        wb_write(ra(REG_WIN_H), 32'h0010_0004);
        wb_write(ra(REG_WIN_V), 32'h0003_0002);
        wb_write(ra(REG_CTRL), 32'h9);
        chk("t2_arm", 32'(dbg_state), 32'(ST_ARM));
        vsync_pulse();
        for (int l = 0; l < 6; l++) send_line(8'h00, 24);
        vsync_pulse();
        chk("t2_idle", 32'(dbg_state), 32'(ST_IDLE));
        rd_chk("t2_status", ra(REG_STATUS), 32'h000C_0002);
        rd_chk("t2_ctrl", ra(REG_CTRL), 32'h8);
        chk("t2_inta", 32'(wb_inta), 32'd1);
        rd_chk("t2_w0", va(0), 32'h0706_0504);
        rd_chk("t2_w3", va(3), 32'h1312_1110);
        rd_chk("t2_w4", va(4), 32'h0706_0504);
        rd_chk("t2_w11", va(11), 32'h1312_1110);
        wb_write(ra(REG_CTRL), 32'h0);
        chk("t2_inta_off", 32'(wb_inta), 32'd0);

        // 3: Y-only format, full words then a zero-padded partial word
        wb_write(ra(REG_WIN_H), 32'h0010_0004);
        wb_write(ra(REG_WIN_V), 32'h0001_0000);
        wb_write(ra(REG_CTRL), 32'h5);
        vsync_pulse();
        send_line(8'h00, 24);
        vsync_pulse();
        rd_chk("t3_status", ra(REG_STATUS), 32'h0002_0002);
        chk("t3_inta", 32'(wb_inta), 32'd0);
        rd_chk("t3_w0", va(0), 32'h0A08_0604);
        rd_chk("t3_w1", va(1), 32'h1210_0E0C);
        wb_write(ra(REG_WIN_H), 32'h0006_0004);
        wb_write(ra(REG_CTRL), 32'h5);
        vsync_pulse();
        send_line(8'h00, 24);
        vsync_pulse();
        rd_chk("t3_pad_status", ra(REG_STATUS), 32'h0001_0002);
        rd_chk("t3_pad_w0", va(0), 32'h0008_0604);
        rd_chk("t3_pad_w1", va(1), 32'h1210_0E0C);

        // 4: window larger than the 16-word VRAM
        wb_write(ra(REG_WIN_H), 32'h0018_0000);
        wb_write(ra(REG_WIN_V), 32'h0003_0000);
        wb_write(ra(REG_CTRL), 32'h1);
        vsync_pulse();
        for (int l = 0; l < 3; l++) send_line(8'h00, 24);
        vsync_pulse();
        rd_chk("t4_status", ra(REG_STATUS), 32'h0010_0006);
        rd_chk("t4_w0", va(0), 32'h0302_0100);
        rd_chk("t4_w15", va(15), 32'h0F0E_0D0C);
        wb_write(ra(REG_STATUS), 32'h6);
        rd_chk("t4_w1c", ra(REG_STATUS), 32'h0010_0000);

        // 5: continuous capture over three frames, then abort mid-line
        wb_write(ra(REG_WIN_H), 32'h0008_0000);
        wb_write(ra(REG_WIN_V), 32'h0001_0000);
        wb_write(ra(REG_CTRL), 32'h3);
        vsync_pulse();
        for (int f = 0; f < 3; f++) begin
            send_line(8'h40 + 8'(f * 64), 8);
            vsync_pulse();
            rd_chk("t5_status", ra(REG_STATUS), 32'h0002_0003);
            wb_write(ra(REG_STATUS), 32'h2);
        end
        rd_chk("t5_w0", va(0), 32'hC3C2_C1C0);
        rd_chk("t5_w1", va(1), 32'hC7C6_C5C4);
        rd_chk("t5_w2_stale", va(2), 32'h0B0A_0908);
        line_begin();
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
        wb_write(ra(REG_CTRL), 32'h0);
        chk("t5_abort_idle", 32'(dbg_state), 32'(ST_IDLE));
        for (int i = 5; i < 8; i++) send_byte(8'h10 + 8'(i));
        line_end();
        vsync_pulse();
        rd_chk("t5_abort_w0", va(0), 32'h1312_1110);
        rd_chk("t5_abort_w1", va(1), 32'hC7C6_C5C4);
        rd_chk("t5_abort_status", ra(REG_STATUS), 32'h0002_0000);

        // 6: read/write collision and W1C coincident with frame_done set
        wb_write(ra(REG_WIN_H), 32'h0004_0000);
        wb_write(ra(REG_CTRL), 32'h1);
        vsync_pulse();
        line_begin();
        for (int i = 0; i < 4; i++) send_byte(8'h20 + 8'(i));
        wb_read(va(0), rd);
        chk("t6_rd_old", rd, 32'h1312_1110);
        rd_chk("t6_rd_new", va(0), 32'h2322_2120);
        line_end();
        cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        wb_write(ra(REG_STATUS), 32'h2);
        repeat (4) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (6) @(negedge clk);
        chk("t6_idle", 32'(dbg_state), 32'(ST_IDLE));
        rd_chk("t6_status", ra(REG_STATUS), 32'h0001_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
